// File: rtl/k005297_cmdsched_if.sv
// Host register bus between the CPU side and the K005297 command scheduler.
// The host (master) drives the strobes; the scheduler (slave) returns read data.
interface k005297_cmdsched_if;
    logic       i_BUS_WR;
    logic       i_BUS_RD;
    logic [1:0] i_BUS_ADDR;
    logic [7:0] i_BUS_DIN;
    logic [7:0] o_BUS_DOUT;

    modport slave (
        input  i_BUS_WR,
        input  i_BUS_RD,
        input  i_BUS_ADDR,
        input  i_BUS_DIN,
        output o_BUS_DOUT
    );

    modport master (
        output i_BUS_WR,
        output i_BUS_RD,
        output i_BUS_ADDR,
        output i_BUS_DIN,
        input  o_BUS_DOUT
    );
endinterface

// File: rtl/k005297_cmdsched.sv
// K005297 command scheduler: 20-slot rotator, host command/page/status registers,
// and slot-aligned commit of read/write page requests with accept/done/error/timeout tracking.
module k005297_cmdsched #(
    parameter int unsigned TIMEOUT_REV = 32'd255
) (
    input  logic                    i_MCLK,
    input  logic                    i_RST_n,
    input  logic                    i_CLK2M_PCEN_n,
    output logic [19:0]             o_ROT20_n,
    k005297_cmdsched_if.slave       bus,
    output logic                    o_CMDREG_RDREQ,
    output logic                    o_CMDREG_WRREQ,
    output logic [11:0]             o_PAGE,
    input  logic                    i_CMD_ACCEPTED_n,
    input  logic                    i_CMDREG_RST_n,
    input  logic                    i_FSMERR_RESTART_n,
    output logic                    o_IRQ_n
);

    localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT_REV);
    localparam logic       TO_ENABLE = (TIMEOUT_REV != 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_PENDING = 2'd2,
        ST_BUSY    = 2'd3
    } state_t;

    state_t      r_state;
    logic [19:0] r_rot;
    logic        r_rdreq;
    logic        r_wrreq;
    logic [11:0] r_page;
    logic [11:0] r_shadow_page;
    logic        r_cmd_wr;
    logic [7:0]  r_to_cnt;
    logic [4:0]  r_sticky;      // {TIMEOUT, DONE, REJECT, OVERRUN, ERR}
    logic        r_irq_n;
    logic [7:0]  r_dout;

    logic        w_en;
    logic        w_slot19;
    logic        w_wr_cmd;
    logic        w_wr_pg_lo;
    logic        w_wr_pg_hi;
    logic        w_rd_stat;
    logic        w_abort;
    logic        w_cmd_go;
    logic        w_cmd_bad;
    logic        w_fsm_err;
    logic        w_fsm_rst;
    logic        w_fsm_acc;
    logic        w_to_hit;
    logic        w_idle;
    logic        w_pending;
    logic        w_busy;
    logic [4:0]  w_set;
    logic [4:0]  w_sticky_nxt;
    logic [7:0]  w_status;

    assign w_en       = ~i_CLK2M_PCEN_n;
    assign w_slot19   = w_en & ~r_rot[19];
    assign w_wr_cmd   = bus.i_BUS_WR & (bus.i_BUS_ADDR == 2'd0);
    assign w_wr_pg_lo = bus.i_BUS_WR & (bus.i_BUS_ADDR == 2'd1);
    assign w_wr_pg_hi = bus.i_BUS_WR & (bus.i_BUS_ADDR == 2'd2);
    assign w_rd_stat  = bus.i_BUS_RD & (bus.i_BUS_ADDR == 2'd0);
    assign w_abort    = w_wr_cmd & bus.i_BUS_DIN[7];
    assign w_cmd_go   = w_wr_cmd & ~bus.i_BUS_DIN[7] & (bus.i_BUS_DIN[0] ^ bus.i_BUS_DIN[1]);
    assign w_cmd_bad  = w_wr_cmd & ~bus.i_BUS_DIN[7] & ~(bus.i_BUS_DIN[0] ^ bus.i_BUS_DIN[1]);
    assign w_fsm_err  = w_en & ~i_FSMERR_RESTART_n;
    assign w_fsm_rst  = w_en & ~i_CMDREG_RST_n;
    assign w_fsm_acc  = w_en & ~i_CMD_ACCEPTED_n;
    assign w_to_hit   = TO_ENABLE & w_slot19 & (r_to_cnt == (TO_LIMIT - 8'd1));
    assign w_idle     = (r_state == ST_IDLE);
    assign w_pending  = (r_state == ST_PENDING);
    assign w_busy     = (r_state == ST_BUSY);

    // Sticky-flag set events; all judged against the pre-edge state, mirroring the FSM priorities.
    assign w_set[0] = ~w_idle & w_fsm_err;
    assign w_set[1] = ~w_idle & (w_wr_pg_lo | w_wr_pg_hi | (w_wr_cmd & (~bus.i_BUS_DIN[7] | w_busy)));
    assign w_set[2] = w_idle & w_cmd_bad;
    assign w_set[3] = (w_pending | w_busy) & ~w_fsm_err & w_fsm_rst;
    assign w_set[4] = w_pending & ~w_fsm_err & ~w_fsm_rst & ~w_abort & ~w_fsm_acc & w_to_hit;

    // A status read clears sticky bits, but a coincident set wins.
    assign w_sticky_nxt = (w_rd_stat ? 5'd0 : r_sticky) | w_set;
    assign w_status     = {r_sticky, w_busy, r_wrreq, r_rdreq};

    assign o_ROT20_n      = r_rot;
    assign o_CMDREG_RDREQ = r_rdreq;
    assign o_CMDREG_WRREQ = r_wrreq;
    assign o_PAGE         = r_page;
    assign o_IRQ_n        = r_irq_n;
    assign bus.o_BUS_DOUT = r_dout;

    // Slot rotator: the single low bit walks up one position per enable.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_rot <= 20'hFFFFE;
        end else if (w_en) begin
            r_rot <= {r_rot[18:0], r_rot[19]};
        end
    end

    // Sticky status flags and the interrupt derived from their next value.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_sticky <= 5'd0;
            r_irq_n  <= 1'b1;
        end else begin
            r_sticky <= w_sticky_nxt;
            r_irq_n  <= ~(w_sticky_nxt[0] | w_sticky_nxt[3] | w_sticky_nxt[4]);
        end
    end

    // Registered host read data.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_dout <= 8'h00;
        end else if (bus.i_BUS_RD) begin
            case (bus.i_BUS_ADDR)
                2'd0:    r_dout <= w_status;
                2'd1:    r_dout <= r_shadow_page[7:0];
                2'd2:    r_dout <= {4'h0, r_shadow_page[11:8]};
                default: r_dout <= 8'h00;
            endcase
        end
    end

    // Shadow page is writable only while no command is outstanding.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_shadow_page <= 12'h000;
        end else if (w_idle && w_wr_pg_lo) begin
            r_shadow_page[7:0] <= bus.i_BUS_DIN;
        end else if (w_idle && w_wr_pg_hi) begin
            r_shadow_page[11:8] <= bus.i_BUS_DIN[3:0];
        end
    end

    // Command FSM: ERR > completion > abort > accept > timeout.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            r_state  <= ST_IDLE;
            r_rdreq  <= 1'b0;
            r_wrreq  <= 1'b0;
            r_page   <= 12'h000;
            r_cmd_wr <= 1'b0;
            r_to_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_go) begin
                        r_cmd_wr <= bus.i_BUS_DIN[1];
                        r_state  <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (w_fsm_err || w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_slot19) begin
                        r_rdreq  <= ~r_cmd_wr;
                        r_wrreq  <= r_cmd_wr;
                        r_page   <= r_shadow_page;
                        r_to_cnt <= 8'd0;
                        r_state  <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (w_fsm_err || w_fsm_rst || w_abort || (!w_fsm_acc && w_to_hit)) begin
                        r_rdreq <= 1'b0;
                        r_wrreq <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_fsm_acc) begin
                        r_state <= ST_BUSY;
                    end else if (w_slot19) begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                ST_BUSY: begin
                    if (w_fsm_err || w_fsm_rst) begin
                        r_rdreq <= 1'b0;
                        r_wrreq <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_rdreq <= 1'b0;
                    r_wrreq <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_k005297_cmdsched.sv
// Directed self-checking bench for k005297_cmdsched (built with TIMEOUT_REV=2).
module tb_k005297_cmdsched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pcen_n;
    logic        acc_n;
    logic        crst_n;
    logic        err_n;
    logic [19:0] rot_n;
    logic        rdreq;
    logic        wrreq;
    logic [11:0] page;
    logic        irq_n;
    logic [7:0]  rd_data;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          pos      = 0;

    always #5 clk = ~clk;

    k005297_cmdsched_if u_bus();

    k005297_cmdsched #(.TIMEOUT_REV(2)) u_dut (
        .i_MCLK             (clk),
        .i_RST_n            (rst_n),
        .i_CLK2M_PCEN_n     (pcen_n),
        .o_ROT20_n          (rot_n),
        .bus                (u_bus),
        .o_CMDREG_RDREQ     (rdreq),
        .o_CMDREG_WRREQ     (wrreq),
        .o_PAGE             (page),
        .i_CMD_ACCEPTED_n   (acc_n),
        .i_CMDREG_RST_n     (crst_n),
        .i_FSMERR_RESTART_n (err_n),
        .o_IRQ_n            (irq_n)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] rot_exp(input int p);
        logic [19:0] one;
        one = 20'd1;
        return ~(one << p);
    endfunction

    task automatic en_step();
        pcen_n = 1'b0;
        @(posedge clk);
        #1;
        pcen_n = 1'b1;
        pos = (pos + 1) % 20;
    endtask

    task automatic fsm_pulse(input logic acc, input logic rst, input logic err);
        acc_n  = ~acc;
        crst_n = ~rst;
        err_n  = ~err;
        en_step();
        acc_n  = 1'b1;
        crst_n = 1'b1;
        err_n  = 1'b1;
    endtask

    task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
        u_bus.i_BUS_WR   = 1'b1;
        u_bus.i_BUS_ADDR = a;
        u_bus.i_BUS_DIN  = d;
        @(posedge clk);
        #1;
        u_bus.i_BUS_WR   = 1'b0;
    endtask

    task automatic host_rd(input logic [1:0] a, output logic [7:0] d);
        u_bus.i_BUS_RD   = 1'b1;
        u_bus.i_BUS_ADDR = a;
        @(posedge clk);
        #1;
        u_bus.i_BUS_RD   = 1'b0;
        d = u_bus.o_BUS_DOUT;
    endtask

    task automatic go_commit();
        while (pos != 19) en_step();
        en_step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; pcen_n = 1'b1; acc_n = 1'b1; crst_n = 1'b1; err_n = 1'b1;
        u_bus.i_BUS_WR = 1'b0; u_bus.i_BUS_RD = 1'b0;
        u_bus.i_BUS_ADDR = 2'd0; u_bus.i_BUS_DIN = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_rot", rot_n, 32'h000FFFFE);
        check_eq("rst_req", {rdreq, wrreq}, 32'd0);
        check_eq("rst_page", page, 32'd0);
        check_eq("rst_dout", u_bus.o_BUS_DOUT, 32'd0);
        check_eq("rst_irq", irq_n, 32'd1);
        rst_n = 1'b1;
        pos = 0;

        // Read commit aligned to the rotator wrapping to bit 0
        host_wr(2'd1, 8'hA5);
        host_wr(2'd2, 8'h02);
        repeat (5) en_step();
        check_eq("rot_pos5", rot_n, rot_exp(5));
        host_wr(2'd0, 8'h01);
        while (pos != 19) begin
            en_step();
            check_eq("rd_early", rdreq, 32'd0);
        end
        en_step();
        check_eq("rd_commit", rdreq, 32'd1);
        check_eq("rd_no_wr", wrreq, 32'd0);
        check_eq("rd_page", page, 32'h2A5);
        check_eq("rd_rot0", rot_n, 32'h000FFFFE);
        host_rd(2'd0, rd_data); check_eq("rd_stat", rd_data, 32'h01);
        host_rd(2'd1, rd_data); check_eq("pg_lo_rb", rd_data, 32'hA5);
        host_rd(2'd2, rd_data); check_eq("pg_hi_rb", rd_data, 32'h02);
        host_rd(2'd3, rd_data); check_eq("addr3_rb", rd_data, 32'h00);
        host_wr(2'd0, 8'h80);
        check_eq("abort_req", {rdreq, wrreq}, 32'd0);
        host_rd(2'd0, rd_data); check_eq("abort_stat", rd_data, 32'h00);
        check_eq("abort_irq", irq_n, 32'd1);

        // Full write flow through accept and completion
        host_wr(2'd0, 8'h02);
        go_commit();
        check_eq("wr_commit", {rdreq, wrreq}, 32'd1);
        repeat (2) en_step();
        fsm_pulse(1'b1, 1'b0, 1'b0);
        host_rd(2'd0, rd_data); check_eq("busy_stat", rd_data, 32'h06);
        repeat (40) en_step();
        check_eq("busy_hold", wrreq, 32'd1);
        fsm_pulse(1'b0, 1'b1, 1'b0);
        check_eq("done_req", wrreq, 32'd0);
        check_eq("done_irq", irq_n, 32'd0);
        host_rd(2'd0, rd_data); check_eq("done_stat", rd_data, 32'h40);
        check_eq("done_irq_clr", irq_n, 32'd1);
        host_rd(2'd0, rd_data); check_eq("done_stat2", rd_data, 32'h00);

        // Reject, then overrun with frozen page
        host_wr(2'd0, 8'h03);
        host_rd(2'd0, rd_data); check_eq("rej_stat", rd_data, 32'h20);
        repeat (20) en_step();
        check_eq("rej_idle", {rdreq, wrreq}, 32'd0);
        host_wr(2'd0, 8'h01);
        go_commit();
        host_wr(2'd1, 8'h55);
        host_rd(2'd0, rd_data); check_eq("ovr_stat", rd_data, 32'h11);
        check_eq("ovr_page", page, 32'h2A5);
        host_rd(2'd1, rd_data); check_eq("ovr_pg_rb", rd_data, 32'hA5);
        host_wr(2'd0, 8'h80);
        check_eq("ovr_abort", rdreq, 32'd0);
        host_rd(2'd0, rd_data); check_eq("ovr_clr", rd_data, 32'h00);

        // Timeout after the second bit-19 enable following commit
        host_wr(2'd0, 8'h01);
        go_commit();
        repeat (19) en_step();
        check_eq("to_pre1", rdreq, 32'd1);
        en_step();
        check_eq("to_rev1", rdreq, 32'd1);
        repeat (19) en_step();
        check_eq("to_pre2", rdreq, 32'd1);
        en_step();
        check_eq("to_drop", rdreq, 32'd0);
        check_eq("to_irq", irq_n, 32'd0);
        host_rd(2'd0, rd_data); check_eq("to_stat", rd_data, 32'h80);
        check_eq("to_irq_clr", irq_n, 32'd1);

        // ERR beats completion in the same enable
        host_wr(2'd0, 8'h02);
        go_commit();
        fsm_pulse(1'b1, 1'b0, 1'b0);
        host_rd(2'd0, rd_data); check_eq("err_busy", rd_data, 32'h06);
        fsm_pulse(1'b0, 1'b1, 1'b1);
        check_eq("err_req", wrreq, 32'd0);
        check_eq("err_irq", irq_n, 32'd0);
        host_rd(2'd0, rd_data); check_eq("err_stat", rd_data, 32'h08);

        // Asynchronous reset while BUSY
        host_wr(2'd0, 8'h01);
        go_commit();
        fsm_pulse(1'b1, 1'b0, 1'b0);
        check_eq("ar_busy", rdreq, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_req", {rdreq, wrreq}, 32'd0);
        check_eq("ar_rot", rot_n, 32'h000FFFFE);
        check_eq("ar_page", page, 32'd0);
        check_eq("ar_dout", u_bus.o_BUS_DOUT, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pos = 0;
        host_rd(2'd0, rd_data); check_eq("ar_stat", rd_data, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
